// File: rtl/typec_pkg.sv
// typec_pkg: shared types, Rp strength codes, default timing and output decode
// for the Type-C source CC controller.
package typec_pkg;

    // Width of the shared debounce / hold counter.
    localparam int unsigned CNT_W = 16;

    // Default timing constants in clk cycles.
    localparam int unsigned DEB_CYC_DEF = 150;  // tCCDebounce
    localparam int unsigned PD_CYC_DEF  = 10;   // tPDDebounce
    localparam int unsigned ERR_CYC_DEF = 25;   // ErrorRecovery hold

    // Rp strength codes as seen on rp_sel_cfg / rp_sel.
    typedef enum logic [1:0] {
        RP_SEL_DEFAULT = 2'd0,  // 36K, default USB power
        RP_SEL_1A5     = 2'd1,  // 12K, 1.5A
        RP_SEL_3A0     = 2'd2,  // 4.7K, 3A
        RP_SEL_3A0_ALT = 2'd3   // 4.7K, 3A (alias)
    } rp_sel_e;

    // Connection state machine states.
    typedef enum logic [2:0] {
        ST_UNATTACHED    = 3'd0,
        ST_ATTACH_WAIT   = 3'd1,
        ST_ATTACHED      = 3'd2,
        ST_UNATTACH_WAIT = 3'd3,
        ST_ERR_RECOVERY  = 3'd4
    } tc_state_e;

    // Bundle of the state-decoded outputs.
    typedef struct packed {
        logic attached;
        logic vbus_en;
        logic cc_sel;
        logic vconn2_en;
        logic vconn1_en;
        logic rp2_en;
        logic rp1_en;
    } tc_outs_t;

    // Moore decode of the output bundle from state, orientation and cable-Ra flag.
    // VCONN only ever goes to the passive CC, and that CC loses its Rp when it does.
    function automatic tc_outs_t decode_outs(input tc_state_e st,
                                             input logic      ori,
                                             input logic      ra_seen);
        tc_outs_t o;
        o = '0;
        case (st)
            ST_UNATTACHED, ST_ATTACH_WAIT: begin
                o.rp1_en = 1'b1;
                o.rp2_en = 1'b1;
            end
            ST_ATTACHED, ST_UNATTACH_WAIT: begin
                o.attached = 1'b1;
                o.vbus_en  = 1'b1;
                o.cc_sel   = ori;
                if (ori) begin
                    o.rp2_en    = 1'b1;
                    o.rp1_en    = ~ra_seen;
                    o.vconn1_en = ra_seen;
                end else begin
                    o.rp1_en    = 1'b1;
                    o.rp2_en    = ~ra_seen;
                    o.vconn2_en = ra_seen;
                end
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/typec_dbnc_cnt.sv
// typec_dbnc_cnt: 16-bit saturating counter with synchronous clear, count
// enable and a compare-against-terminal flag.
module typec_dbnc_cnt
    import typec_pkg::*;
(
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             at_term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable, and the count holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/typec_src_ctl.sv
// typec_src_ctl: USB Type-C source-side CC connection controller.
// Debounces Rd presence on CC1/CC2, selects orientation, drives Rp, VCONN and
// VBUS, and handles detach debounce and ErrorRecovery.
module typec_src_ctl
    import typec_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned PD_CYC  = PD_CYC_DEF,
    parameter int unsigned ERR_CYC = ERR_CYC_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       cc1_rd,
    input  logic       cc2_rd,
    input  logic       cc1_ra,
    input  logic       cc2_ra,
    input  logic       err_rec,
    input  logic [1:0] rp_sel_cfg,
    output logic       rp1_en,
    output logic       rp2_en,
    output logic [1:0] rp_sel,
    output logic       vconn1_en,
    output logic       vconn2_en,
    output logic       cc_sel,
    output logic       vbus_en,
    output logic       attached
);

    // Terminal counts: a wait of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] PD_TERM  = CNT_W'(PD_CYC - 1);
    localparam logic [CNT_W-1:0] ERR_TERM = CNT_W'(ERR_CYC - 1);

    // Synchronizer stages, bit order {cc2_ra, cc1_ra, cc2_rd, cc1_rd}.
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic       s_cc1_rd;
    logic       s_cc2_rd;
    logic       s_cc1_ra;
    logic       s_cc2_ra;

    tc_state_e  state_q;
    tc_state_e  state_d;
    logic       ori_q;
    logic       ori_d;
    logic       ra_seen_q;
    logic       ra_seen_d;
    tc_outs_t   outs_q;
    logic [1:0] rp_sel_q;

    logic             one_rd;
    logic             act_rd;
    logic             oth_ra;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_at_term;
    logic [CNT_W-1:0] cnt_term_val;

    // Two-flop synchronizers for the asynchronous comparator inputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {cc2_ra, cc1_ra, cc2_rd, cc1_rd};
            sync2_q <= sync1_q;
        end
    end

    assign s_cc1_rd = sync2_q[0];
    assign s_cc2_rd = sync2_q[1];
    assign s_cc1_ra = sync2_q[2];
    assign s_cc2_ra = sync2_q[3];

    // Exactly one Rd present; the active CC's Rd and the passive CC's Ra.
    assign one_rd = s_cc1_rd ^ s_cc2_rd;
    assign act_rd = ori_q ? s_cc2_rd : s_cc1_rd;
    assign oth_ra = ori_q ? s_cc1_ra : s_cc2_ra;

    // Counter terminal value depends on which wait the current state is timing.
    always_comb begin
        case (state_q)
            ST_ATTACH_WAIT:   cnt_term_val = DEB_TERM;
            ST_UNATTACH_WAIT: cnt_term_val = PD_TERM;
            ST_ERR_RECOVERY:  cnt_term_val = ERR_TERM;
            default:          cnt_term_val = '1;
        endcase
    end

    typec_dbnc_cnt u_cnt (
        .clk_i     (clk),
        .srst_i    (srst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .term_i    (cnt_term_val),
        .at_term_o (cnt_at_term)
    );

    // Next-state, orientation, Ra capture and counter control; err_rec beats everything.
    always_comb begin
        state_d   = state_q;
        ori_d     = ori_q;
        ra_seen_d = ra_seen_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        if (err_rec) begin
            state_d = ST_ERR_RECOVERY;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_UNATTACHED: begin
                    if (one_rd) begin
                        state_d = ST_ATTACH_WAIT;
                        ori_d   = s_cc2_rd;
                        cnt_clr = 1'b1;
                    end
                end
                ST_ATTACH_WAIT: begin
                    // The entry pattern is implied by ori: stable means the Rd
                    // still sits on the CC that ori points at.
                    if (!one_rd) begin
                        state_d = ST_UNATTACHED;
                    end else if (s_cc2_rd != ori_q) begin
                        ori_d   = s_cc2_rd;
                        cnt_clr = 1'b1;
                    end else if (cnt_at_term) begin
                        state_d   = ST_ATTACHED;
                        ra_seen_d = oth_ra;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_ATTACHED: begin
                    if (!act_rd) begin
                        state_d = ST_UNATTACH_WAIT;
                        cnt_clr = 1'b1;
                    end
                end
                ST_UNATTACH_WAIT: begin
                    if (act_rd) begin
                        state_d = ST_ATTACHED;
                    end else if (cnt_at_term) begin
                        state_d = ST_UNATTACHED;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_ERR_RECOVERY: begin
                    if (cnt_at_term) begin
                        state_d = ST_UNATTACHED;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_UNATTACHED;
                end
            endcase
        end
    end

    // State registers; outputs are decoded from the next state so they change
    // on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= ST_UNATTACHED;
            ori_q     <= 1'b0;
            ra_seen_q <= 1'b0;
            outs_q    <= decode_outs(ST_UNATTACHED, 1'b0, 1'b0);
        end else begin
            state_q   <= state_d;
            ori_q     <= ori_d;
            ra_seen_q <= ra_seen_d;
            outs_q    <= decode_outs(state_d, ori_d, ra_seen_d);
        end
    end

    // Registered copy of the Rp strength selection.
    always_ff @(posedge clk) begin
        if (srst) begin
            rp_sel_q <= RP_SEL_DEFAULT;
        end else begin
            rp_sel_q <= rp_sel_cfg;
        end
    end

    assign rp1_en    = outs_q.rp1_en;
    assign rp2_en    = outs_q.rp2_en;
    assign vconn1_en = outs_q.vconn1_en;
    assign vconn2_en = outs_q.vconn2_en;
    assign cc_sel    = outs_q.cc_sel;
    assign vbus_en   = outs_q.vbus_en;
    assign attached  = outs_q.attached;
    assign rp_sel    = rp_sel_q;

endmodule

// File: tb/tb_typec_src_ctl.sv
// tb_typec_src_ctl: scenario bench for typec_src_ctl with short timing.
// Each scenario schedules expected output vectors by cycle number and checks
// them as the cycle count reaches each due point.
module tb_typec_src_ctl;

    localparam int unsigned DEB = 8;
    localparam int unsigned PD  = 4;
    localparam int unsigned ERR = 5;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       cc1_rd = 1'b0;
    logic       cc2_rd = 1'b0;
    logic       cc1_ra = 1'b0;
    logic       cc2_ra = 1'b0;
    logic       err_rec = 1'b0;
    logic [1:0] rp_sel_cfg = 2'd0;
    logic       rp1_en, rp2_en, vconn1_en, vconn2_en, cc_sel, vbus_en, attached;
    logic [1:0] rp_sel;

    typec_src_ctl #(.DEB_CYC(DEB), .PD_CYC(PD), .ERR_CYC(ERR)) dut (
        .clk        (clk),
        .srst       (srst),
        .cc1_rd     (cc1_rd),
        .cc2_rd     (cc2_rd),
        .cc1_ra     (cc1_ra),
        .cc2_ra     (cc2_ra),
        .err_rec    (err_rec),
        .rp_sel_cfg (rp_sel_cfg),
        .rp1_en     (rp1_en),
        .rp2_en     (rp2_en),
        .rp_sel     (rp_sel),
        .vconn1_en  (vconn1_en),
        .vconn2_en  (vconn2_en),
        .cc_sel     (cc_sel),
        .vbus_en    (vbus_en),
        .attached   (attached)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [8:0]  val;
        string       tag;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Vector layout: {attached, vbus_en, cc_sel, vconn2, vconn1, rp2, rp1, rp_sel[1:0]}
    function automatic logic [8:0] v_un(input logic [1:0] rs);
        return {5'b00000, 1'b1, 1'b1, rs};
    endfunction

    function automatic logic [8:0] v_err(input logic [1:0] rs);
        return {7'b0000000, rs};
    endfunction

    function automatic logic [8:0] v_att(input logic ori, input logic ra, input logic [1:0] rs);
        logic v1, v2;
        v1 = ori & ra;
        v2 = ~ori & ra;
        return {1'b1, 1'b1, ori, v2, v1, ~v2, ~v1, rs};
    endfunction

    function automatic logic [8:0] obs();
        return {attached, vbus_en, cc_sel, vconn2_en, vconn1_en, rp2_en, rp1_en, rp_sel};
    endfunction

    task automatic expect_at(input int unsigned due, input logic [8:0] val, input string tag);
        sb_t e;
        e.due = due;
        e.val = val;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        cc1_rd = 1'b0; cc2_rd = 1'b0; cc1_ra = 1'b0; cc2_ra = 1'b0;
        err_rec = 1'b0; rp_sel_cfg = 2'd0;
        step();
        step();
        srst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        int unsigned c;
        sb_t e;
        c = cyc;
        srst = 1'b1; cc1_rd = 1'b1; cc2_ra = 1'b1; err_rec = 1'b1; rp_sel_cfg = 2'd3;
        expect_at(c + 1, v_un(2'd0), "reset_assert");
        expect_at(c + 3, v_un(2'd0), "reset_hold");
        expect_at(c + 8, v_un(2'd0), "reset_release");
        for (int t = 1; t <= 9; t++) begin
            step();
            if (t == 3) begin
                srst = 1'b0; cc1_rd = 1'b0; cc2_ra = 1'b0; err_rec = 1'b0; rp_sel_cfg = 2'd0;
            end
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_rp_sel();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        rp_sel_cfg = 2'd1;
        expect_at(c + 1, v_un(2'd1), "rpsel_1");
        expect_at(c + 2, v_un(2'd2), "rpsel_2");
        expect_at(c + 3, v_un(2'd3), "rpsel_3");
        expect_at(c + 4, v_un(2'd0), "rpsel_0");
        for (int t = 1; t <= 5; t++) begin
            step();
            if (t == 1) rp_sel_cfg = 2'd2;
            if (t == 2) rp_sel_cfg = 2'd3;
            if (t == 3) rp_sel_cfg = 2'd0;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_attach();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        cc1_rd = 1'b1;
        expect_at(c + 10, v_un(2'd0), "attach_debouncing");
        expect_at(c + 11, v_att(1'b0, 1'b0, 2'd0), "attach_done");
        expect_at(c + 16, v_att(1'b0, 1'b0, 2'd0), "attach_hold");
        for (int t = 1; t <= 17; t++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_flip_ra();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        cc2_rd = 1'b1; cc1_ra = 1'b1;
        expect_at(c + 10, v_un(2'd0), "flip_debouncing");
        expect_at(c + 11, v_att(1'b1, 1'b1, 2'd0), "flip_ra_attach");
        expect_at(c + 14, v_att(1'b1, 1'b1, 2'd0), "flip_ra_hold");
        for (int t = 1; t <= 15; t++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_glitch_detach();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        cc1_rd = 1'b1; cc2_ra = 1'b1;
        expect_at(c + 11, v_att(1'b0, 1'b1, 2'd0), "glitch_attach");
        for (int t = 1; t <= 33; t++) begin
            step();
            if (t == 12) begin
                cc1_rd = 1'b0;
                for (int unsigned i = 13; i <= 22; i++)
                    expect_at(c + i, v_att(1'b0, 1'b1, 2'd0), "glitch_short");
            end
            if (t == 15) cc1_rd = 1'b1;
            if (t == 22) begin
                cc1_rd = 1'b0;
                expect_at(c + 28, v_att(1'b0, 1'b1, 2'd0), "detach_pd_wait");
                expect_at(c + 29, v_un(2'd0), "detach_done");
                expect_at(c + 32, v_un(2'd0), "detach_stay");
            end
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        cc1_rd = 1'b1;
        for (int unsigned i = 1; i <= 20; i++)
            expect_at(c + i, v_un(2'd0), "bounce_pulse");
        for (int t = 1; t <= 40; t++) begin
            step();
            if (t == 5) cc1_rd = 1'b0;
            if (t == 20) begin
                cc1_rd = 1'b1;
                expect_at(c + 31, v_un(2'd0), "bounce_restart");
                expect_at(c + 37, v_un(2'd0), "bounce_restart_wait");
                expect_at(c + 38, v_att(1'b1, 1'b0, 2'd0), "bounce_attach_cc2");
            end
            if (t == 27) begin
                cc1_rd = 1'b0;
                cc2_rd = 1'b1;
            end
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_err_rec();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        cc1_rd = 1'b1;
        expect_at(c + 11, v_att(1'b0, 1'b0, 2'd0), "err_pre_attach");
        for (int t = 1; t <= 29; t++) begin
            step();
            if (t == 13) begin
                err_rec = 1'b1;
                for (int unsigned i = 14; i <= 18; i++)
                    expect_at(c + i, v_err(2'd0), "err_hold");
                expect_at(c + 19, v_un(2'd0), "err_exit");
                expect_at(c + 27, v_un(2'd0), "err_redebounce");
                expect_at(c + 28, v_att(1'b0, 1'b0, 2'd0), "err_reattach");
            end
            if (t == 14) err_rec = 1'b0;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_err_vs_debounce();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        cc1_rd = 1'b1;
        expect_at(c + 10, v_un(2'd0), "race_debouncing");
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 10) begin
                err_rec = 1'b1;
                for (int unsigned i = 11; i <= 18; i++)
                    expect_at(c + i, v_err(2'd0), "race_err_wins");
                expect_at(c + 19, v_un(2'd0), "race_err_restart_exit");
            end
            if (t == 11) err_rec = 1'b0;
            if (t == 13) err_rec = 1'b1;
            if (t == 14) err_rec = 1'b0;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    task automatic test_srst_mid();
        int unsigned c;
        sb_t e;
        do_reset();
        c = cyc;
        rp_sel_cfg = 2'd2; cc2_rd = 1'b1; cc1_ra = 1'b1;
        expect_at(c + 11, v_att(1'b1, 1'b1, 2'd2), "srst_pre_attach");
        for (int t = 1; t <= 26; t++) begin
            step();
            if (t == 13) begin
                srst = 1'b1;
                err_rec = 1'b1;
                expect_at(c + 14, v_un(2'd0), "srst_clear");
                expect_at(c + 15, v_un(2'd2), "srst_rpsel_back");
                expect_at(c + 24, v_un(2'd2), "srst_resync");
                expect_at(c + 25, v_att(1'b1, 1'b1, 2'd2), "srst_reattach");
            end
            if (t == 14) begin
                srst = 1'b0;
                err_rec = 1'b0;
            end
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b expected %b", e.tag, cyc, obs(), e.val);
                end
            end
        end
    endtask

    initial begin
        step();
        test_reset();
        test_rp_sel();
        test_attach();
        test_flip_ra();
        test_glitch_detach();
        test_bounce();
        test_err_rec();
        test_err_vs_debounce();
        test_srst_mid();
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/typec_src_ctl.md
TYPEC_SRC_CTL -- requirements
Module: typec_src_ctl

Interface
REQ-001 Parameter DEB_CYC, default 150: tCCDebounce in clk cycles, range 2..65535.
REQ-002 Parameter PD_CYC, default 10: tPDDebounce in clk cycles, range 2..65535.
REQ-003 Parameter ERR_CYC, default 25: ErrorRecovery hold time in clk cycles, range 2..65535.
REQ-004 clk  input  1  sole clock; all flops rising-edge.
REQ-005 srst  input  1  synchronous active-high reset.
REQ-006 cc1_rd, cc2_rd  input  1 each  comparator: CCx voltage inside Rd window; asynchronous.
REQ-007 cc1_ra, cc2_ra  input  1 each  comparator: CCx voltage inside Ra window; asynchronous.
REQ-008 err_rec  input  1  synchronous pulse that forces ErrorRecovery.
REQ-009 rp_sel_cfg  input  2  Rp strength: 0 = 36K default, 1 = 12K 1.5A, 2/3 = 4.7K 3A.
REQ-010 rp1_en, rp2_en  output  1 each  Rp enable on CC1/CC2.
REQ-011 rp_sel  output  2  registered copy of rp_sel_cfg.
REQ-012 vconn1_en, vconn2_en  output  1 each  VCONN switch on CC1/CC2.
REQ-013 cc_sel  output  1  orientation: 0 = CC1 active, 1 = CC2 active.
REQ-014 vbus_en  output  1  VBUS source switch.
REQ-015 attached  output  1  state == ATTACHED or UNATTACH_WAIT.

Function
REQ-016 cc1_rd, cc2_rd, cc1_ra and cc2_ra pass through 2-flop synchronizers; all decisions use synchronized values (s_*).
REQ-017 States: UNATTACHED, ATTACH_WAIT, ATTACHED, UNATTACH_WAIT, ERR_RECOVERY; outputs are Moore-decoded from the state, ori and ra_seen registers.
REQ-018 UNATTACHED: rp1_en = rp2_en = 1, vconn*_en = 0, vbus_en = 0; exactly one s_ccX_rd = 1 -> ATTACH_WAIT, ori <= (s_cc2_rd), cnt <= 0; both or neither -> stay.
REQ-019 ATTACH_WAIT: outputs as UNATTACHED; cnt increments while the {s_cc1_rd, s_cc2_rd} pattern equals its entry value; pattern changes to another single-Rd -> ori updated, cnt <= 0; no Rd or both -> UNATTACHED; cnt == DEB_CYC-1 with stable pattern -> ATTACHED, ra_seen <= s_ra on the non-active CC.
REQ-020 ATTACHED: vbus_en = 1, cc_sel = ori; active-CC Rp on; if ra_seen, the other CC has Rp off and VCONN on, else Rp on and VCONN off; active-CC s_rd = 0 -> UNATTACH_WAIT, cnt <= 0.
REQ-021 UNATTACH_WAIT: outputs as ATTACHED; active s_rd returns to 1 -> ATTACHED, ra_seen unchanged; cnt == PD_CYC-1 -> UNATTACHED, clearing vbus_en and VCONN on the same edge.
REQ-022 ERR_RECOVERY: all rp/vconn/vbus outputs 0; stay ERR_CYC cycles, then UNATTACHED.
REQ-023 err_rec = 1 in any state -> ERR_RECOVERY, cnt <= 0; it takes priority over every other transition; err_rec inside ERR_RECOVERY restarts cnt.
REQ-024 cnt is 16 bits and saturates, never wraps.
REQ-025 rp_sel updates 1 cycle after rp_sel_cfg in any state.
REQ-026 vconn1_en and vconn2_en are never both 1; VCONN is never on the CC selected by cc_sel.

Reset
REQ-027 srst high at a clk edge -> state UNATTACHED, cnt = 0, ori = 0, ra_seen = 0, synchronizers = 0, rp_sel = 0; outputs thereafter rp1_en = rp2_en = 1, all other outputs 0.
REQ-028 srst asserted mid-ATTACHED drops vbus_en and VCONN on the same edge; srst overrides err_rec.

Structure
REQ-029 Shared package typec_pkg holds the state enum, the RP_SEL_* codes and the default timing constants.
REQ-030 One sub-module, typec_dbnc_cnt: 16-bit saturating counter with clear, enable and terminal-compare outputs, instantiated once.

Verification (bench: DEB_CYC=8, PD_CYC=4, ERR_CYC=5)
REQ-031 Attach, no cable Ra: cc1_rd rises at edge k -> attached = 1 and vbus_en = 1 after edge k+10, cc_sel = 0, rp1_en = rp2_en = 1, vconn*_en = 0.
REQ-032 Flipped attach with Ra: cc2_rd = 1 and cc1_ra = 1 stable -> cc_sel = 1, vconn1_en = 1, rp1_en = 0, rp2_en = 1.
REQ-033 Glitchy detach: in ATTACHED, drop active Rd for 3 cycles (synchronized) -> attached and vbus_en stay 1; drop for 6 cycles -> UNATTACHED, vbus_en = 0, both Rp on.
REQ-034 Bounce during ATTACH_WAIT: cc1_rd pulse of 5 cycles -> never ATTACHED; toggling the pattern cc1 -> cc2 at cnt = 6 restarts cnt, and ATTACHED is reached 8 cycles later with cc_sel = 1.
REQ-035 err_rec in ATTACHED -> next cycle all enables 0 for 5 cycles, then rp1_en = rp2_en = 1; err_rec concurrent with a debounce expiry wins.
REQ-036 srst pulsed in ATTACHED with VCONN on -> after the edge, vbus_en = vconn*_en = 0, rp_sel = 0, state UNATTACHED.
